// File: rtl/instr_decoder_pkg.sv
// Shared constants and types for the 16-bit instruction decoder: opcode/ext codes,
// ALU operation encodings, FSM states and the per-operation property lookup.
package instr_decoder_pkg;

    localparam logic [3:0] OP_REG   = 4'b0000;
    localparam logic [3:0] CODE_ADD = 4'b0101;
    localparam logic [3:0] CODE_SUB = 4'b1001;
    localparam logic [3:0] CODE_CMP = 4'b1011;
    localparam logic [3:0] CODE_AND = 4'b0001;
    localparam logic [3:0] CODE_OR  = 4'b0010;
    localparam logic [3:0] CODE_XOR = 4'b0011;
    localparam logic [3:0] CODE_MOV = 4'b1101;

    typedef enum logic [3:0] {
        ALU_NOP = 4'h0,
        ALU_ADD = 4'h1,
        ALU_SUB = 4'h2,
        ALU_CMP = 4'h3,
        ALU_AND = 4'h4,
        ALU_OR  = 4'h5,
        ALU_XOR = 4'h6,
        ALU_MOV = 4'h7
    } alu_op_t;

    typedef enum logic [1:0] {
        ST_IDLE   = 2'd0,
        ST_DECODE = 2'd1,
        ST_EXEC   = 2'd2,
        ST_WB     = 2'd3
    } state_t;

    typedef struct packed {
        alu_op_t alu_op;
        logic    wr_en;
        logic    flag_en;
        logic    sign_ext;
        logic    legal;
    } op_info_t;

    // The same code space serves both the register-form ext field and the immediate-form op field.
    function automatic op_info_t op_lookup(input logic [3:0] code);
        op_info_t info;
        info = '{alu_op: ALU_NOP, wr_en: 1'b0, flag_en: 1'b0, sign_ext: 1'b0, legal: 1'b0};
        case (code)
            CODE_ADD: info = '{alu_op: ALU_ADD, wr_en: 1'b1, flag_en: 1'b1, sign_ext: 1'b1, legal: 1'b1};
            CODE_SUB: info = '{alu_op: ALU_SUB, wr_en: 1'b1, flag_en: 1'b1, sign_ext: 1'b1, legal: 1'b1};
            CODE_CMP: info = '{alu_op: ALU_CMP, wr_en: 1'b0, flag_en: 1'b1, sign_ext: 1'b1, legal: 1'b1};
            CODE_AND: info = '{alu_op: ALU_AND, wr_en: 1'b1, flag_en: 1'b0, sign_ext: 1'b0, legal: 1'b1};
            CODE_OR:  info = '{alu_op: ALU_OR,  wr_en: 1'b1, flag_en: 1'b0, sign_ext: 1'b0, legal: 1'b1};
            CODE_XOR: info = '{alu_op: ALU_XOR, wr_en: 1'b1, flag_en: 1'b0, sign_ext: 1'b0, legal: 1'b1};
            CODE_MOV: info = '{alu_op: ALU_MOV, wr_en: 1'b1, flag_en: 1'b0, sign_ext: 1'b1, legal: 1'b1};
            default:  ;
        endcase
        return info;
    endfunction

endpackage

// File: rtl/instr_decoder_imm_extend.sv
// Widens an 8-bit immediate to 16 bits, sign- or zero-extending on request.
module imm_extend (
    input  logic [7:0]  i_imm8,
    input  logic        i_sign_sel,
    output logic [15:0] o_imm16
);

    assign o_imm16 = {{8{i_sign_sel & i_imm8[7]}}, i_imm8};

endmodule

// File: rtl/instr_decoder.sv
// Multi-cycle instruction decoder: IDLE/DECODE/EXEC/WB handshake FSM with registered
// decode fields and single-cycle writeback strobes.
module instr_decoder
    import instr_decoder_pkg::*;
(
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] instr,
    input  logic        instr_valid,
    output logic        instr_ready,
    output logic        ri,
    output logic [15:0] imm,
    output logic [3:0]  rsrc_addr,
    output logic [3:0]  rdest_addr,
    output logic [3:0]  alu_op,
    output logic        reg_we,
    output logic        flag_we,
    output logic        illegal,
    output logic        busy
);

    state_t   r_state;
    state_t   w_state_next;
    logic     w_accept;

    logic [3:0]  w_op;
    logic [3:0]  w_ext;
    logic        w_is_reg;
    op_info_t    w_info;
    logic        w_ri;
    logic [15:0] w_imm_ext;
    logic [15:0] w_imm;

    logic        r_ri;
    logic [15:0] r_imm;
    logic [3:0]  r_rsrc;
    logic [3:0]  r_rdest;
    alu_op_t     r_alu_op;
    logic        r_wr_en;
    logic        r_flag_en;
    logic        r_illegal;

    assign w_op     = instr[15:12];
    assign w_ext    = instr[7:4];
    assign w_is_reg = (w_op == OP_REG);
    assign w_info   = op_lookup(w_is_reg ? w_ext : w_op);
    assign w_ri     = !w_is_reg && w_info.legal;

    imm_extend u_imm_extend (
        .i_imm8     (instr[7:0]),
        .i_sign_sel (w_info.sign_ext),
        .o_imm16    (w_imm_ext)
    );

    // Register forms and illegal words never present an immediate.
    assign w_imm    = w_ri ? w_imm_ext : 16'h0000;
    assign w_accept = (r_state == ST_IDLE) && instr_valid;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            ST_IDLE:   if (w_accept) w_state_next = ST_DECODE;
            ST_DECODE: w_state_next = ST_EXEC;
            ST_EXEC:   w_state_next = ST_WB;
            ST_WB:     w_state_next = ST_IDLE;
            default:   w_state_next = ST_IDLE;
        endcase
    end

    // Decode fields are captured only on the accepting edge and held until the next one.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_ri      <= 1'b0;
            r_imm     <= 16'h0000;
            r_rsrc    <= 4'h0;
            r_rdest   <= 4'h0;
            r_alu_op  <= ALU_NOP;
            r_wr_en   <= 1'b0;
            r_flag_en <= 1'b0;
            r_illegal <= 1'b0;
        end else if (w_accept) begin
            r_ri      <= w_ri;
            r_imm     <= w_imm;
            r_rsrc    <= instr[3:0];
            r_rdest   <= instr[11:8];
            r_alu_op  <= w_info.alu_op;
            r_wr_en   <= w_info.wr_en;
            r_flag_en <= w_info.flag_en;
            r_illegal <= !w_info.legal;
        end
    end

    assign instr_ready = (r_state == ST_IDLE);
    assign busy        = (r_state != ST_IDLE);
    assign ri          = r_ri;
    assign imm         = r_imm;
    assign rsrc_addr   = r_rsrc;
    assign rdest_addr  = r_rdest;
    assign alu_op      = r_alu_op;
    assign reg_we      = (r_state == ST_WB) && r_wr_en;
    assign flag_we     = (r_state == ST_WB) && r_flag_en;
    assign illegal     = (r_state == ST_WB) && r_illegal;

endmodule

// File: tb/tb_instr_decoder.sv
// Directed-vector bench for instr_decoder with hand-computed expected decode results.
module tb_instr_decoder;
    import instr_decoder_pkg::*;

    logic        clk = 1'b0;
    logic        reset;
    logic [15:0] instr;
    logic        instr_valid;
    logic        instr_ready;
    logic        ri;
    logic [15:0] imm;
    logic [3:0]  rsrc_addr;
    logic [3:0]  rdest_addr;
    logic [3:0]  alu_op;
    logic        reg_we;
    logic        flag_we;
    logic        illegal;
    logic        busy;

    int n_cmp = 0;
    int n_bad = 0;

    always #5 clk = ~clk;

    instr_decoder dut (
        .clk         (clk),
        .reset       (reset),
        .instr       (instr),
        .instr_valid (instr_valid),
        .instr_ready (instr_ready),
        .ri          (ri),
        .imm         (imm),
        .rsrc_addr   (rsrc_addr),
        .rdest_addr  (rdest_addr),
        .alu_op      (alu_op),
        .reg_we      (reg_we),
        .flag_we     (flag_we),
        .illegal     (illegal),
        .busy        (busy)
    );

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic check_reset_vals(input string tag);
        check_val({tag, ".ri"},      ri,          1'b0);
        check_val({tag, ".imm"},     imm,         16'h0000);
        check_val({tag, ".rsrc"},    rsrc_addr,   4'h0);
        check_val({tag, ".rdest"},   rdest_addr,  4'h0);
        check_val({tag, ".alu"},     alu_op,      4'h0);
        check_val({tag, ".strobes"}, {reg_we, flag_we, illegal}, 3'b000);
        check_val({tag, ".busy"},    busy,        1'b0);
        check_val({tag, ".ready"},   instr_ready, 1'b1);
    endtask

    task automatic check_fields(input string tag, input logic e_ri, input logic [15:0] e_imm,
                                input logic [3:0] e_rd, input logic [3:0] e_rs, input logic [3:0] e_alu);
        check_val({tag, ".ri"},    ri,         e_ri);
        check_val({tag, ".imm"},   imm,        e_imm);
        check_val({tag, ".rdest"}, rdest_addr, e_rd);
        check_val({tag, ".rsrc"},  rsrc_addr,  e_rs);
        check_val({tag, ".alu"},   alu_op,     e_alu);
    endtask

    // Full pass of one instruction: accept, DECODE, EXEC, WB, back to IDLE.
    task automatic run_instr(input string tag, input logic [15:0] w, input logic e_ri,
                             input logic [15:0] e_imm, input logic [3:0] e_alu,
                             input logic e_we, input logic e_fw, input logic e_ill);
        @(negedge clk);
        instr = w;
        instr_valid = 1'b1;
        check_val({tag, ".ready_idle"}, instr_ready, 1'b1);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        instr = ~w;
        check_val({tag, ".dec_busy"}, {busy, instr_ready}, 2'b10);
        check_fields({tag, ".dec"}, e_ri, e_imm, w[11:8], w[3:0], e_alu);
        check_val({tag, ".dec_strb"}, {reg_we, flag_we, illegal}, 3'b000);
        @(posedge clk); #1;
        check_fields({tag, ".exe"}, e_ri, e_imm, w[11:8], w[3:0], e_alu);
        check_val({tag, ".exe_strb"}, {reg_we, flag_we, illegal}, 3'b000);
        @(posedge clk); #1;
        check_val({tag, ".wb_busy"}, busy, 1'b1);
        check_val({tag, ".wb_strb"}, {reg_we, flag_we, illegal}, {e_we, e_fw, e_ill});
        check_fields({tag, ".wb"}, e_ri, e_imm, w[11:8], w[3:0], e_alu);
        @(posedge clk); #1;
        check_val({tag, ".idle_rdy"}, {busy, instr_ready}, 2'b01);
        check_val({tag, ".idle_strb"}, {reg_we, flag_we, illegal}, 3'b000);
        check_fields({tag, ".idle_hold"}, e_ri, e_imm, w[11:8], w[3:0], e_alu);
    endtask

    initial begin
        reset = 1'b1;
        instr = 16'h0000;
        instr_valid = 1'b0;
        #12;
        check_reset_vals("rst");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check_reset_vals("post_rst");

        run_instr("add",   16'h0355, 1'b0, 16'h0000, ALU_ADD, 1'b1, 1'b1, 1'b0);
        run_instr("addi",  16'h52FF, 1'b1, 16'hFFFF, ALU_ADD, 1'b1, 1'b1, 1'b0);
        run_instr("andi",  16'h1180, 1'b1, 16'h0080, ALU_AND, 1'b1, 1'b0, 1'b0);
        run_instr("cmpi",  16'hB405, 1'b1, 16'h0005, ALU_CMP, 1'b0, 1'b1, 1'b0);
        run_instr("ill7",  16'h7000, 1'b0, 16'h0000, ALU_NOP, 1'b0, 1'b0, 1'b1);
        run_instr("cmp",   16'h04B2, 1'b0, 16'h0000, ALU_CMP, 1'b0, 1'b1, 1'b0);
        run_instr("mov",   16'h01D7, 1'b0, 16'h0000, ALU_MOV, 1'b1, 1'b0, 1'b0);
        run_instr("illx",  16'h0040, 1'b0, 16'h0000, ALU_NOP, 1'b0, 1'b0, 1'b1);
        run_instr("ori",   16'h21F0, 1'b1, 16'h00F0, ALU_OR,  1'b1, 1'b0, 1'b0);
        run_instr("xori",  16'h3AFF, 1'b1, 16'h00FF, ALU_XOR, 1'b1, 1'b0, 1'b0);
        run_instr("subi",  16'h9A80, 1'b1, 16'hFF80, ALU_SUB, 1'b1, 1'b1, 1'b0);
        run_instr("movi",  16'hD57F, 1'b1, 16'h007F, ALU_MOV, 1'b1, 1'b0, 1'b0);
        run_instr("sub",   16'h0E93, 1'b0, 16'h0000, ALU_SUB, 1'b1, 1'b1, 1'b0);

        // instr_valid held high with a new word while busy: ignored until IDLE.
        @(negedge clk);
        instr = 16'h0355;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr = 16'h52FF;
        for (int c = 0; c < 3; c++) begin
            check_fields($sformatf("hold.c%0d", c), 1'b0, 16'h0000, 4'h3, 4'h5, ALU_ADD);
            check_val($sformatf("hold.rdy%0d", c), instr_ready, 1'b0);
            @(posedge clk); #1;
        end
        check_val("hold.idle_rdy", instr_ready, 1'b1);
        check_fields("hold.idle", 1'b0, 16'h0000, 4'h3, 4'h5, ALU_ADD);
        @(posedge clk); #1;
        instr_valid = 1'b0;
        check_val("hold.reaccept_busy", busy, 1'b1);
        check_fields("hold.reaccept", 1'b1, 16'hFFFF, 4'h2, 4'hF, ALU_ADD);
        repeat (3) @(posedge clk);
        #1;
        check_val("hold.done", instr_ready, 1'b1);

        // Reset asserted mid-EXEC aborts the instruction with no strobes.
        @(negedge clk);
        instr = 16'h52FF;
        instr_valid = 1'b1;
        @(posedge clk); #1;
        instr_valid = 1'b0;
        @(posedge clk); #1;
        check_val("abort.exec_busy", busy, 1'b1);
        #2;
        reset = 1'b1;
        #1;
        check_reset_vals("abort.async");
        @(posedge clk); #1;
        check_val("abort.no_wb", {reg_we, flag_we, illegal}, 3'b000);
        check_reset_vals("abort.held");
        @(negedge clk);
        reset = 1'b0;
        @(posedge clk); #1;
        check_val("abort.no_wb2", {reg_we, flag_we, illegal}, 3'b000);
        check_val("abort.ready", instr_ready, 1'b1);

        run_instr("after", 16'h0355, 1'b0, 16'h0000, ALU_ADD, 1'b1, 1'b1, 1'b0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #100000;
        $display("FAIL timeout: got no_finish expected finish");
        $fatal(1, "timeout");
    end

endmodule
